// File: rtl/pattern_mode_sequencer.sv
// pattern_mode_sequencer
//   Owns the DIGI/PATTRN source select for the event-window datapath.
//   A requested mode change is applied only at an event-window boundary.
//   The sequencer first drains the open window from the active source and
//   then holds a guard gap, so no window ever mixes DIGI and PATTRN data.
//
// Ports (all on serdesclk):
//   serdesclk        150 MHz clock
//   reset_serdesclk  synchronous active-high reset, dominant
//   pattern_req      requested mode (1 = PATTRN, 0 = DIGI)
//   axi_start_in     event-window start pulse
//   DIGI_ew_done     window-complete pulse from the DIGI path
//   PATTRN_ew_done   window-complete pulse from the PATTRN path
//   timeout_clr      clears drain_timeout
//   pattern_en       registered source select to the switch mux
//   axi_start_out    registered, gated start pulse to the switch mux
//   switch_busy      high while draining or guarding
//   drain_timeout    sticky: a drain was forced by timeout
//   dropped_starts   saturating count of suppressed starts
//   switch_count     saturating count of completed source flips
module pattern_mode_sequencer #(
  parameter int unsigned GUARD_CYCLES  = 8,
  parameter int unsigned DRAIN_TIMEOUT = 4096,
  parameter int unsigned TO_BITS       = 13,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic                serdesclk,
  input  logic                reset_serdesclk,
  input  logic                pattern_req,
  input  logic                axi_start_in,
  input  logic                DIGI_ew_done,
  input  logic                PATTRN_ew_done,
  input  logic                timeout_clr,
  output logic                pattern_en,
  output logic                axi_start_out,
  output logic                switch_busy,
  output logic                drain_timeout,
  output logic [CNT_BITS-1:0] dropped_starts,
  output logic [CNT_BITS-1:0] switch_count
);

  typedef enum logic [1:0] {
    DIGI_RUN,
    PATTRN_RUN,
    DRAIN,
    GUARD
  } state_t;

  localparam logic [TO_BITS-1:0]  DRAIN_LAST = TO_BITS'(DRAIN_TIMEOUT - 1);
  localparam logic [TO_BITS-1:0]  GUARD_LAST = TO_BITS'(GUARD_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

  state_t             state;
  logic               window_open;
  logic [TO_BITS-1:0] cnt;

  logic active_done;
  logic in_run;
  logic start_fwd;
  logic drain_flip;
  logic timeout_fire;

  always_comb begin
    active_done  = pattern_en ? PATTRN_ew_done : DIGI_ew_done;
    in_run       = (state == DIGI_RUN) || (state == PATTRN_RUN);
    start_fwd    = in_run && axi_start_in;
    // Abort (request withdrawn) outranks every way of completing the drain.
    drain_flip   = (state == DRAIN) && (pattern_req != pattern_en) &&
                   (!window_open || active_done || (cnt == DRAIN_LAST));
    timeout_fire = drain_flip && window_open && !active_done;
  end

  always_ff @(posedge serdesclk) begin
    if (reset_serdesclk) begin
      state          <= DIGI_RUN;
      pattern_en     <= 1'b0;
      axi_start_out  <= 1'b0;
      switch_busy    <= 1'b0;
      drain_timeout  <= 1'b0;
      dropped_starts <= '0;
      switch_count   <= '0;
      window_open    <= 1'b0;
      cnt            <= '0;
    end else begin
      axi_start_out <= 1'b0;

      // A start forwarded this cycle reopens the window even if the old one
      // closes on the same edge.
      window_open   <= start_fwd | (window_open & ~active_done & ~timeout_fire);

      // Set wins over a simultaneous clear.
      drain_timeout <= timeout_fire | (drain_timeout & ~timeout_clr);

      if (!in_run && axi_start_in && (dropped_starts != CNT_MAX))
        dropped_starts <= dropped_starts + 1'b1;

      unique case (state)
        DIGI_RUN, PATTRN_RUN: begin
          axi_start_out <= axi_start_in;
          if (pattern_req != pattern_en) begin
            state       <= DRAIN;
            cnt         <= '0;
            switch_busy <= 1'b1;
          end
        end

        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (pattern_req == pattern_en) begin
            state       <= pattern_en ? PATTRN_RUN : DIGI_RUN;
            switch_busy <= 1'b0;
          end else if (drain_flip) begin
            pattern_en <= ~pattern_en;
            if (switch_count != CNT_MAX)
              switch_count <= switch_count + 1'b1;
            cnt   <= '0;
            state <= GUARD;
          end
        end

        GUARD: begin
          if (cnt == GUARD_LAST) begin
            state       <= pattern_en ? PATTRN_RUN : DIGI_RUN;
            cnt         <= '0;
            switch_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= DIGI_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_mode_sequencer.sv
module tb_pattern_mode_sequencer;

  logic serdesclk = 1'b0;
  logic reset_serdesclk = 1'b1;
  logic pattern_req = 1'b0;
  logic axi_start_in = 1'b0;
  logic DIGI_ew_done = 1'b0;
  logic PATTRN_ew_done = 1'b0;
  logic timeout_clr = 1'b0;

  logic        pe_a, so_a, busy_a, to_a;
  logic [15:0] drop_a, sc_a;
  logic        pe_b, so_b, busy_b, to_b;
  logic [1:0]  drop_b, sc_b;

  int checks = 0;
  int errors = 0;

  always #5 serdesclk = ~serdesclk;

  // Long-timeout instance with full-width counters.
  pattern_mode_sequencer #(
    .GUARD_CYCLES (8),
    .DRAIN_TIMEOUT(4096),
    .TO_BITS      (13),
    .CNT_BITS     (16)
  ) dut_a (
    .serdesclk      (serdesclk),
    .reset_serdesclk(reset_serdesclk),
    .pattern_req    (pattern_req),
    .axi_start_in   (axi_start_in),
    .DIGI_ew_done   (DIGI_ew_done),
    .PATTRN_ew_done (PATTRN_ew_done),
    .timeout_clr    (timeout_clr),
    .pattern_en     (pe_a),
    .axi_start_out  (so_a),
    .switch_busy    (busy_a),
    .drain_timeout  (to_a),
    .dropped_starts (drop_a),
    .switch_count   (sc_a)
  );

  // Short-timeout instance with 2-bit counters for timeout and saturation.
  pattern_mode_sequencer #(
    .GUARD_CYCLES (8),
    .DRAIN_TIMEOUT(16),
    .TO_BITS      (5),
    .CNT_BITS     (2)
  ) dut_b (
    .serdesclk      (serdesclk),
    .reset_serdesclk(reset_serdesclk),
    .pattern_req    (pattern_req),
    .axi_start_in   (axi_start_in),
    .DIGI_ew_done   (DIGI_ew_done),
    .PATTRN_ew_done (PATTRN_ew_done),
    .timeout_clr    (timeout_clr),
    .pattern_en     (pe_b),
    .axi_start_out  (so_b),
    .switch_busy    (busy_b),
    .drain_timeout  (to_b),
    .dropped_starts (drop_b),
    .switch_count   (sc_b)
  );

  typedef struct {
    logic rst, req, st, dd, pd, clr;
    logic pe, so, busy;
    int   drop, sc;
    logic to;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic req, input logic st,
                     input logic dd, input logic pd, input logic clr);
    @(negedge serdesclk);
    reset_serdesclk = rst;
    pattern_req     = req;
    axi_start_in    = st;
    DIGI_ew_done    = dd;
    PATTRN_ew_done  = pd;
    timeout_clr     = clr;
    @(posedge serdesclk);
    #1;
  endtask

  initial begin
    // rst req st dd pd clr | pe so busy drop sc to
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0};
    vecs[7]  = '{0, 1, 1, 0, 0, 0,  1, 0, 1, 1, 1, 0};
    for (int i = 8; i <= 13; i++)
      vecs[i] = '{0, 1, 0, 0, 0, 0,  1, 0, 1, 1, 1, 0};
    vecs[14] = '{0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0};
    vecs[15] = '{0, 1, 1, 0, 0, 0,  1, 1, 0, 1, 1, 0};
    vecs[16] = '{0, 1, 0, 0, 1, 0,  1, 0, 0, 1, 1, 0};

    // Basic forward, idle switch to PATTRN, 1 drain + 8 guard cycles.
    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].rst, vecs[i].req, vecs[i].st, vecs[i].dd, vecs[i].pd, vecs[i].clr);
      chk($sformatf("v%0d_pattern_en", i),    int'(pe_a),   int'(vecs[i].pe));
      chk($sformatf("v%0d_start_out", i),     int'(so_a),   int'(vecs[i].so));
      chk($sformatf("v%0d_busy", i),          int'(busy_a), int'(vecs[i].busy));
      chk($sformatf("v%0d_dropped", i),       int'(drop_a), vecs[i].drop);
      chk($sformatf("v%0d_switch_count", i),  int'(sc_a),   vecs[i].sc);
      chk($sformatf("v%0d_drain_timeout", i), int'(to_a),   int'(vecs[i].to));
    end

    // Drain of an open window, closed by DIGI done 50 cycles later.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("drain_fwd_start", int'(so_a), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("drain_enter_busy", int'(busy_a), 1);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("drain_pattrn_done_ignored_pe", int'(pe_a), 0);
    chk("drain_pattrn_done_ignored_busy", int'(busy_a), 1);
    cyc(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 45; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("drain_hold_pe", int'(pe_a), 0);
    chk("drain_hold_dropped", int'(drop_a), 2);
    cyc(0, 1, 0, 1, 0, 0);
    chk("drain_done_pe", int'(pe_a), 1);
    chk("drain_done_switch_count", int'(sc_a), 1);
    chk("drain_done_dropped", int'(drop_a), 2);
    chk("drain_done_no_timeout", int'(to_a), 0);

    // Forced switch after exactly 16 drain cycles (short instance).
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("to_before_pe", int'(pe_b), 0);
    chk("to_before_flag", int'(to_b), 0);
    chk("to_before_busy", int'(busy_b), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("to_flip_pe", int'(pe_b), 1);
    chk("to_flip_flag", int'(to_b), 1);
    chk("to_flip_switch_count", int'(sc_b), 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("to_sticky", int'(to_b), 1);
    cyc(0, 1, 0, 0, 0, 1);
    chk("to_cleared", int'(to_b), 0);

    // Request withdrawn while draining; start on request cycle still forwarded.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("abort_req_cycle_fwd", int'(so_a), 1);
    chk("abort_req_cycle_busy", int'(busy_a), 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_pe", int'(pe_a), 0);
    chk("abort_switch_count", int'(sc_a), 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("abort_run_fwd", int'(so_a), 1);

    // Saturation of dropped_starts on the 2-bit instance.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0);
    chk("sat_dropped_wide", int'(drop_a), 5);
    chk("sat_dropped_narrow", int'(drop_b), 3);
    chk("sat_guard_busy", int'(busy_a), 1);

    // Reset mid-guard after switching to PATTRN.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("rst_guard_pre_pe", int'(pe_a), 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("rst_guard_pe", int'(pe_a), 0);
    chk("rst_guard_busy", int'(busy_a), 0);
    chk("rst_guard_dropped", int'(drop_a), 0);
    chk("rst_guard_switch_count", int'(sc_a), 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("rst_guard_digi_fwd", int'(so_a), 1);
    chk("rst_guard_digi_busy", int'(busy_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
